// File: rtl/beat_sequencer_pkg.sv
// rtl/beat_sequencer_pkg.sv - shared types and constants for the beat sequencer
package beat_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic PH_SCAN   = 1'b0;
  localparam logic PH_ACTION = 1'b1;

  localparam int DEF_CI_BEAT    = 1;
  localparam int DEF_FETCH_BEAT = 3;
  localparam int DEF_EXEC_BEAT  = 4;

endpackage

// File: rtl/beat_onehot_check.sv
// rtl/beat_onehot_check.sv - flags multi-hot and all-zero beat vectors
module beat_onehot_check #(
  parameter int W = 13
) (
  input  logic [W-1:0] beat_i,
  output logic         multi_o,
  output logic         zero_o
);

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(beat_i & (beat_i - W'(1)));
  assign zero_o  = (beat_i == '0);

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - SCAN/ACTION machine-cycle sequencer with run state
module beat_sequencer
  import beat_sequencer_pkg::*;
#(
  parameter int SUB_CYCLES = 13,
  parameter int CI_BEAT    = DEF_CI_BEAT,
  parameter int FETCH_BEAT = DEF_FETCH_BEAT,
  parameter int EXEC_BEAT  = DEF_EXEC_BEAT,
  parameter int CNT_W      = 16
) (
  input  logic                  in_CLK,
  input  logic                  in_RST_N,
  input  logic [SUB_CYCLES-1:0] b_CONTROLLER,
  input  logic                  in_RUN,
  input  logic                  in_STEP,
  input  logic                  in_CLEAR,
  input  logic                  in_STOP_INSTR,
  output logic                  o_PHASE,
  output logic                  o_CI_INC,
  output logic                  o_PI_LOAD,
  output logic                  o_EXEC,
  output logic                  o_RUNNING,
  output logic                  o_HALTED,
  output logic                  o_BEAT_ERR,
  output logic [CNT_W-1:0]      o_INSTR_CNT
);

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic             step_pend_q, step_pend_d;
  logic             stop_pend_q, stop_pend_d;
  logic             ci_q, ci_d, pi_q, pi_d, exec_q, exec_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic multi, zero, valid, last_beat;

  beat_onehot_check #(.W(SUB_CYCLES)) u_check (
    .beat_i  (b_CONTROLLER),
    .multi_o (multi),
    .zero_o  (zero)
  );

  assign valid     = !multi && !zero;
  assign last_beat = b_CONTROLLER[SUB_CYCLES-1];

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    step_pend_d = step_pend_q;
    stop_pend_d = stop_pend_q;
    ci_d        = 1'b0;
    pi_d        = 1'b0;
    exec_d      = 1'b0;
    err_d       = err_q | multi;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_STEP) step_pend_d = 1'b1;
        if (valid && last_beat) begin
          phase_d = PH_SCAN;
          if (in_RUN) begin
            state_d = ST_RUN;
          end else if (step_pend_q) begin
            state_d     = ST_STEP;
            step_pend_d = 1'b0;
          end
        end
      end
      ST_RUN, ST_STEP: begin
        if (phase_q == PH_SCAN) begin
          ci_d = valid && b_CONTROLLER[CI_BEAT];
          pi_d = valid && b_CONTROLLER[FETCH_BEAT];
          if (valid && last_beat) phase_d = PH_ACTION;
        end else begin
          if (valid && b_CONTROLLER[EXEC_BEAT]) begin
            exec_d      = 1'b1;
            stop_pend_d = in_STOP_INSTR;
          end
          // Raw last-beat bit so a corrupted completion beat still counts.
          if (last_beat) begin
            cnt_d       = cnt_q + CNT_W'(1);
            phase_d     = PH_SCAN;
            stop_pend_d = 1'b0;
            if (stop_pend_q)                           state_d = ST_HALT;
            else if (state_q == ST_STEP || !in_RUN)    state_d = ST_IDLE;
            else                                       state_d = ST_RUN;
          end
        end
        if (multi) begin
          state_d     = ST_HALT;
          phase_d     = PH_SCAN;
          stop_pend_d = 1'b0;
        end
      end
      ST_HALT: begin
        if (in_CLEAR) begin
          state_d     = ST_IDLE;
          step_pend_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_SCAN;
      step_pend_q <= 1'b0;
      stop_pend_q <= 1'b0;
      ci_q        <= 1'b0;
      pi_q        <= 1'b0;
      exec_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_pend_q <= step_pend_d;
      stop_pend_q <= stop_pend_d;
      ci_q        <= ci_d;
      pi_q        <= pi_d;
      exec_q      <= exec_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_PHASE     = phase_q;
  assign o_CI_INC    = ci_q;
  assign o_PI_LOAD   = pi_q;
  assign o_EXEC      = exec_q;
  assign o_RUNNING   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign o_HALTED    = (state_q == ST_HALT);
  assign o_BEAT_ERR  = err_q;
  assign o_INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - directed self-checking bench for beat_sequencer
module tb_beat_sequencer;

  logic        in_CLK = 1'b0;
  logic        in_RST_N;
  logic [12:0] b_CONTROLLER;
  logic        in_RUN, in_STEP, in_CLEAR, in_STOP_INSTR;
  logic        o_PHASE, o_CI_INC, o_PI_LOAD, o_EXEC, o_RUNNING, o_HALTED, o_BEAT_ERR;
  logic [15:0] o_INSTR_CNT;

  int checks = 0;
  int errors = 0;
  int bi = 0;
  int n_ci, n_pi, n_ex, pos_ci, pos_pi, pos_ex, sum_ci, guard;
  logic seen_run;

  beat_sequencer dut (
    .in_CLK        (in_CLK),
    .in_RST_N      (in_RST_N),
    .b_CONTROLLER  (b_CONTROLLER),
    .in_RUN        (in_RUN),
    .in_STEP       (in_STEP),
    .in_CLEAR      (in_CLEAR),
    .in_STOP_INSTR (in_STOP_INSTR),
    .o_PHASE       (o_PHASE),
    .o_CI_INC      (o_CI_INC),
    .o_PI_LOAD     (o_PI_LOAD),
    .o_EXEC        (o_EXEC),
    .o_RUNNING     (o_RUNNING),
    .o_HALTED      (o_HALTED),
    .o_BEAT_ERR    (o_BEAT_ERR),
    .o_INSTR_CNT   (o_INSTR_CNT)
  );

  always #5 in_CLK = ~in_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then present the next beat of the rotating one-hot vector.
  task automatic tick();
    @(posedge in_CLK);
    #1;
    bi = (bi + 1) % 13;
    b_CONTROLLER = 13'd1 << bi;
  endtask

  task automatic tally();
    if (o_CI_INC)  n_ci++;
    if (o_PI_LOAD) n_pi++;
    if (o_EXEC)    n_ex++;
  endtask

  task automatic clr_tally();
    n_ci = 0; n_pi = 0; n_ex = 0;
  endtask

  function automatic logic [6:0] outs();
    return {o_PHASE, o_CI_INC, o_PI_LOAD, o_EXEC, o_RUNNING, o_HALTED, o_BEAT_ERR};
  endfunction

  initial begin
    in_RST_N = 1'b0; in_RUN = 1'b1; in_STEP = 1'b0; in_CLEAR = 1'b0; in_STOP_INSTR = 1'b0;
    b_CONTROLLER = 13'd1;
    #3;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_cnt", 32'(o_INSTR_CNT), 32'd0);
    tick(); tick();
    in_RST_N = 1'b1;

    // Run from reset: enter RUN on first sampled beat 12, then three instructions.
    while (bi != 12) tick();
    tick();
    chk("enter_run", 32'(o_RUNNING), 32'd1);
    chk("enter_phase", 32'(o_PHASE), 32'd0);
    clr_tally(); pos_ci = 0; pos_pi = 0; pos_ex = 0; sum_ci = 0;
    for (int n = 1; n <= 78; n++) begin
      tick();
      tally();
      if (o_CI_INC) sum_ci += n;
      if (o_CI_INC && pos_ci == 0)  pos_ci = n;
      if (o_PI_LOAD && pos_pi == 0) pos_pi = n;
      if (o_EXEC && pos_ex == 0)    pos_ex = n;
      if (n == 13) chk("phase_action", 32'(o_PHASE), 32'd1);
      if (n == 26) chk("phase_scan_cnt1", {15'd0, o_PHASE, o_INSTR_CNT}, 32'h0000_0001);
    end
    chk("ci_first", 32'(pos_ci), 32'd2);
    chk("pi_first", 32'(pos_pi), 32'd4);
    chk("exec_first", 32'(pos_ex), 32'd18);
    chk("ci_period", 32'(sum_ci), 32'd84);
    chk("strobe_counts", {8'(n_ci), 8'(n_pi), 8'(n_ex), 8'd0}, {8'd3, 8'd3, 8'd3, 8'd0});
    chk("cnt_after_78", 32'(o_INSTR_CNT), 32'd3);
    chk("still_running", 32'(o_RUNNING), 32'd1);

    // Drop RUN at ACTION beat 6: instruction finishes, then idle.
    clr_tally();
    for (int m = 1; m <= 26; m++) begin
      if (m == 20) in_RUN = 1'b0;
      tick();
      tally();
      if (m == 25) chk("run_til_done", 32'(o_RUNNING), 32'd1);
    end
    chk("drop_strobes", {8'(n_ci), 8'(n_pi), 8'(n_ex)}, {8'd1, 8'd1, 8'd1});
    chk("drop_idle", {o_RUNNING, o_HALTED, o_INSTR_CNT}, {2'b00, 16'd4});
    clr_tally();
    for (int m = 0; m < 40; m++) begin tick(); tally(); end
    chk("idle_quiet", 32'(n_ci + n_pi + n_ex), 32'd0);

    // Single step.
    in_STEP = 1'b1; tick(); in_STEP = 1'b0;
    clr_tally(); seen_run = 1'b0;
    for (int m = 0; m < 60; m++) begin
      tick(); tally();
      if (o_RUNNING) seen_run = 1'b1;
    end
    chk("step_ran", 32'(seen_run), 32'd1);
    chk("step_strobes", {8'(n_ci), 8'(n_pi), 8'(n_ex)}, {8'd1, 8'd1, 8'd1});
    chk("step_done", {o_RUNNING, o_HALTED, o_INSTR_CNT}, {2'b00, 16'd5});

    // Stop instruction leads to HALT.
    in_RUN = 1'b1; in_STOP_INSTR = 1'b1;
    guard = 0;
    while (!o_HALTED && guard < 60) begin tick(); guard++; end
    chk("halt_reached", 32'(o_HALTED), 32'd1);
    chk("halt_state", {o_RUNNING, o_PHASE, o_INSTR_CNT}, {2'b00, 16'd6});
    in_STOP_INSTR = 1'b0;
    in_STEP = 1'b1; tick(); in_STEP = 1'b0;
    clr_tally();
    for (int m = 0; m < 30; m++) begin tick(); tally(); end
    chk("halt_ignores_step", {o_HALTED, o_RUNNING, 8'(n_ci + n_pi + n_ex)}, {2'b10, 8'd0});
    in_CLEAR = 1'b1; tick(); in_CLEAR = 1'b0;
    chk("clear_to_idle", {o_HALTED, o_RUNNING}, 2'b00);
    guard = 0;
    while (!o_RUNNING && guard < 20) begin tick(); guard++; end
    chk("resume_run", 32'(o_RUNNING), 32'd1);

    // Corrupted beat mid-SCAN.
    while (bi != 5) tick();
    b_CONTROLLER = 13'h0003;
    tick();
    chk("err_halt", {o_BEAT_ERR, o_HALTED, o_RUNNING}, 3'b110);
    chk("err_no_strobe", {o_CI_INC, o_PI_LOAD, o_EXEC, o_PHASE}, 4'b0000);
    in_CLEAR = 1'b1; tick(); in_CLEAR = 1'b0;
    chk("err_sticky", {o_BEAT_ERR, o_HALTED}, 2'b10);
    in_RST_N = 1'b0;
    #1;
    chk("err_reset", 32'(o_BEAT_ERR), 32'd0);

    // Asynchronous reset at ACTION beat 6.
    in_RUN = 1'b1;
    in_RST_N = 1'b1;
    guard = 0;
    while (!(o_PHASE && bi == 6) && guard < 60) begin tick(); guard++; end
    chk("reach_action6", {o_PHASE, o_RUNNING}, 2'b11);
    in_RST_N = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'd0);
    chk("async_reset_cnt", 32'(o_INSTR_CNT), 32'd0);
    tick();
    in_RST_N = 1'b1;
    for (int m = 0; m < 4; m++) tick();
    chk("post_reset_idle", {o_RUNNING, o_INSTR_CNT}, 17'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
